// File: rtl/dff_ram_pkg.sv
// Shared opcodes and FSM state encoding for the flip-flop RAM controller.
package dff_ram_pkg;

   localparam logic [2:0] OP_WRITE     = 3'd0;
   localparam logic [2:0] OP_READ      = 3'd1;
   localparam logic [2:0] OP_SET_PTR   = 3'd2;
   localparam logic [2:0] OP_WRITE_INC = 3'd3;
   localparam logic [2:0] OP_READ_INC  = 3'd4;
   localparam logic [2:0] OP_CLEAR     = 3'd5;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/dff_ram_array.sv
// DATA_W x DEPTH flip-flop storage: one synchronous write port, one combinational read port.
// No reset on the storage; contents persist across rst.
module dff_ram_array #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dff_ram_ctrl.sv
// Command front end for the DFF RAM: one command per cycle in IDLE, reads registered (1-cycle latency).
// CLEAR zeroes one word per cycle for DEPTH cycles with cmd_ready low; cmd_ready depends on state only.
module dff_ram_ctrl
   import dff_ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW-1:0]     ptr,
   output logic              busy
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d, clr_cnt_q, clr_cnt_d, ptr_inc;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_ok, arr_we;
   logic [AW-1:0]     arr_waddr, arr_raddr;
   logic [DATA_W-1:0] arr_wdata, arr_rdata;

   // Non-power-of-two depths leave encodable addresses that map to no word.
   assign addr_ok   = ({1'b0, cmd_addr} < (AW + 1)'(DEPTH));
   assign ptr_inc   = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
   assign arr_raddr = (cmd_op == OP_READ_INC) ? ptr_q : cmd_addr;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_cnt_d  = clr_cnt_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      arr_we     = 1'b0;
      arr_waddr  = cmd_addr;
      arr_wdata  = cmd_wdata;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_WRITE: arr_we = addr_ok;
                  OP_READ: begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = addr_ok ? arr_rdata : '0;
                  end
                  OP_SET_PTR: begin
                     if (addr_ok) ptr_d = cmd_addr;
                  end
                  OP_WRITE_INC: begin
                     arr_we    = 1'b1;
                     arr_waddr = ptr_q;
                     ptr_d     = ptr_inc;
                  end
                  OP_READ_INC: begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = arr_rdata;
                     ptr_d      = ptr_inc;
                  end
                  OP_CLEAR: begin
                     state_d   = CLEAR;
                     clr_cnt_d = '0;
                  end
                  default: ;
               endcase
            end
         end
         CLEAR: begin
            arr_we    = 1'b1;
            arr_waddr = clr_cnt_q;
            arr_wdata = '0;
            if (clr_cnt_q == LAST) state_d = IDLE;
            else                   clr_cnt_d = clr_cnt_q + AW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         clr_cnt_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         clr_cnt_q  <= clr_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   dff_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i   (clk),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .raddr_i (arr_raddr),
      .rdata_o (arr_rdata)
   );

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == CLEAR);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign ptr       = ptr_q;

endmodule

// File: doc/dff_ram_ctrl.md
# dff_ram_ctrl

Parametrised flip-flop RAM with a command interface. It is the next generation of the team's fixed 16-byte DFF memory: data width and depth are configurable, and it adds a valid/ready command handshake, an auto-incrementing burst pointer, and a self-timed clear. It sits between the chip I/O decode logic and any on-die consumer that needs small scratch storage.

## Interface
- `DATA_W`, 8, word width in bits (1..32).
- `DEPTH`, 16, number of words (2..256; need not be a power of two).
- `AW`, localparam `$clog2(DEPTH)`, address width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  3  opcode (see Operation).
- `cmd_addr`  in  AW  address for WRITE, READ and SET_PTR.
- `cmd_wdata`  in  DATA_W  write data.
- `rd_valid`  out  1  one-cycle pulse: `rd_data` is updated.
- `rd_data`  out  DATA_W  last read result, held between reads.
- `ptr`  out  AW  current burst pointer.
- `busy`  out  1  CLEAR in progress.

## Operation
- A command is accepted on a cycle where `cmd_valid && cmd_ready`. Inputs are sampled only on that cycle.
- Opcodes:
  - 0 WRITE: `mem[cmd_addr] = cmd_wdata`.
  - 1 READ: `rd_data = mem[cmd_addr]`.
  - 2 SET_PTR: `ptr = cmd_addr`.
  - 3 WRITE_INC: `mem[ptr] = cmd_wdata`, then `ptr++`.
  - 4 READ_INC: `rd_data = mem[ptr]`, then `ptr++`.
  - 5 CLEAR: zero all words.
  - 6 and 7: NOP. Accepted, no effect.
- Pointer increment wraps from DEPTH-1 to 0.
- Out-of-range address (`cmd_addr >= DEPTH`):
  - WRITE is dropped.
  - READ returns 0 with `rd_valid` asserted.
  - SET_PTR is ignored; `ptr` is unchanged.
- State machine has two states: IDLE and CLEAR.
  - IDLE: `cmd_ready=1`. An accepted CLEAR moves to CLEAR and loads the clear counter with 0.
  - CLEAR: `cmd_ready=0`, `busy=1`. One word is zeroed per cycle, at address = counter. After writing DEPTH-1 the block returns to IDLE.
- CLEAR does not change `ptr` or `rd_data`.
- The memory array has no reset; its contents after `rst` are undefined.
- Reset during CLEAR aborts the clear. Words not yet cleared keep their contents, and the block returns to IDLE.

## Timing
- Reset values: `cmd_ready=1`, `rd_valid=0`, `rd_data=0`, `ptr=0`, `busy=0`, state IDLE.
- Write latency: the word is updated at the accepting edge and is readable by a READ accepted on the next cycle.
- Read latency: 1 cycle. `rd_valid` and `rd_data` update at the edge that accepts the READ or READ_INC, so they are visible the cycle after acceptance.
- `rd_valid` is high for exactly one cycle per read. Back-to-back reads give consecutive `rd_valid` pulses.
- Throughput: one command per cycle in IDLE.
- CLEAR timing:
  - `busy` rises the cycle after acceptance and stays high for exactly DEPTH cycles.
  - `cmd_ready` is low for those same DEPTH cycles.
  - The next command can be accepted DEPTH+1 cycles after the CLEAR edge.
- `cmd_ready` is a function of state only. It does not depend on `cmd_valid` combinationally.
- Pointer update: `ptr` takes its new value at the accepting edge. READ_INC reads the pre-increment pointer.
- Back-to-back WRITE_INC then READ_INC: the read uses the incremented pointer, not the written location.

## Structure
- Package `dff_ram_pkg` holds:
  - opcode constants `OP_WRITE`, `OP_READ`, `OP_SET_PTR`, `OP_WRITE_INC`, `OP_READ_INC`, `OP_CLEAR`;
  - the state encoding IDLE/CLEAR.
- Sub-module `dff_ram_array`: DATA_W × DEPTH flip-flop storage with one synchronous write port and one combinational read port, and no reset. `dff_ram_ctrl` contains the FSM, pointer, clear counter and read register, and muxes the array write port between command writes and clear writes.

## Test plan
- Reset, then WRITE addr 3 ← 0xA5, then READ addr 3 -> `rd_valid` pulses one cycle later with `rd_data=0xA5`; `rd_data` is held afterwards with `rd_valid=0`.
- SET_PTR 14, then WRITE_INC 0x11, 0x22, 0x33 (DEPTH=16) -> `ptr` reads 15, 0, 1; `mem[14]=0x11`, `mem[15]=0x22`, `mem[0]=0x33`. Then SET_PTR 14 and three READ_INC -> 0x11, 0x22, 0x33.
- Fill all words with non-zero values, then CLEAR -> `busy` and `!cmd_ready` for exactly 16 cycles; every READ afterwards returns 0; `ptr` is unchanged.
- DEPTH=12, AW=4: WRITE addr 13 is dropped (`mem` unchanged); READ addr 13 -> `rd_data=0`, `rd_valid=1`; SET_PTR 13 leaves `ptr` unchanged; WRITE_INC at `ptr=11` wraps `ptr` to 0.
- Assert `rst` on the 5th cycle of a CLEAR -> all outputs at reset values immediately; words 0..3 read 0 and words 4..15 keep their old data.
- Stream four READs on consecutive cycles, including one with `cmd_valid` low mid-stream -> `rd_valid` pulses match the accepted commands one-for-one with correct data. Opcode 7 causes no change.
